// File: rtl/keypad_pkg.sv
// Shared keypad types and constants: key code encodings, interrupt FSM states,
// and the code-to-ASCII mapping used on the FIFO read path.
package keypad_pkg;

  typedef logic [3:0] key_code_t;

  localparam key_code_t KEY_NONE = 4'hF;
  localparam key_code_t KEY_STAR = 4'hA;
  localparam key_code_t KEY_HASH = 4'hB;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    WAIT_ACK
  } int_state_t;

  function automatic logic [7:0] key_to_ascii(input key_code_t code);
    logic [7:0] ascii;
    if (code <= 4'h9)          ascii = 8'h30 + {4'h0, code};
    else if (code == KEY_STAR) ascii = 8'h2A;
    else if (code == KEY_HASH) ascii = 8'h23;
    else                       ascii = 8'h3F;
    return ascii;
  endfunction

endpackage

// File: rtl/key_int_pulse_fsm.sv
// Interrupt generator: fires a fixed-width INTERRUPT pulse while keys are pending
// and re-arms once the MCU has popped an entry.
module key_int_pulse_fsm
  import keypad_pkg::*;
#(
  parameter int unsigned INT_PULSE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic empty,
  input  logic rd_strb,
  output logic INTERRUPT
);

  localparam int unsigned CW = (INT_PULSE_CYCLES > 1) ? $clog2(INT_PULSE_CYCLES) : 1;

  int_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic        ack_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  // A pop seen during the pulse is remembered so the pulse still runs full length.
  assign ack_seen = ack_q | (rd_strb & ~empty);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_d     = ack_q;
    INTERRUPT = 1'b0;
    unique case (state_q)
      IDLE: begin
        ack_d = 1'b0;
        if (!empty) begin
          state_d = PULSE;
          cnt_d   = CW'(INT_PULSE_CYCLES - 1);
        end
      end
      PULSE: begin
        INTERRUPT = 1'b1;
        ack_d     = ack_seen;
        if (cnt_q == '0) begin
          state_d = ack_seen ? IDLE : WAIT_ACK;
          ack_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WAIT_ACK: begin
        if (rd_strb && !empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/keypad_key_fifo.sv
// Key FIFO between the keypad scanner and the RAT MCU, with pulsed interrupt.
// Define KEY_ASCII_EN to present rd_data as ASCII instead of the raw 4-bit code.
module keypad_key_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned DEPTH            = 8,
  parameter int unsigned INT_PULSE_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               key_code,
  input  logic                     REG_LD,
  input  logic                     rd_strb,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     INTERRUPT
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  key_code_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            reg_ld_q;
  logic            push_req, pop, do_push;
  key_code_t       head;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNTW'(DEPTH));
  assign count    = count_q;
  assign overflow = overflow_q;

  // A pop while full frees a slot in the same cycle, so the push is not dropped.
  always_comb begin
    push_req   = REG_LD & ~reg_ld_q & (key_code != KEY_NONE);
    pop        = rd_strb & ~empty;
    do_push    = push_req & (~full | pop);
    wr_ptr_d   = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CNTW'(do_push) - CNTW'(pop);
    overflow_d = overflow_q | (push_req & full & ~pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      reg_ld_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      reg_ld_q   <= REG_LD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= key_code;
    end
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    rd_data = 8'h00;
    if (!empty) begin
`ifdef KEY_ASCII_EN
      rd_data = key_to_ascii(head);
`else
      rd_data = {4'h0, head};
`endif
    end
  end

  key_int_pulse_fsm #(
    .INT_PULSE_CYCLES(INT_PULSE_CYCLES)
  ) u_int_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .empty    (empty),
    .rd_strb  (rd_strb),
    .INTERRUPT(INTERRUPT)
  );

endmodule
